// File: rtl/qf_rfm_pkg.sv
// Shared types and default geometry for the FCB register-file memory reader.
package qf_rfm_pkg;

    localparam int unsigned RFM_WIDTH_DEF = 64;
    localparam int unsigned RFM_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rfr_state_e;

endpackage

// File: rtl/qf_rfm_rdr.sv
// Sequential reader: walks a wrapping address range of the register file and
// streams each captured word out on a valid/ready interface with a last marker.
module qf_rfm_rdr
    import qf_rfm_pkg::*;
#(
    parameter int unsigned PAR_MEMORY_WIDTH_BIT = RFM_WIDTH_DEF,
    parameter int unsigned PAR_MEMORY_DEPTH_BIT = RFM_DEPTH_DEF
) (
    input  logic                            rfr_clk,
    input  logic                            rfr_rst,
    input  logic                            rfr_start,
    input  logic [PAR_MEMORY_DEPTH_BIT-1:0] rfr_start_addr,
    input  logic [PAR_MEMORY_DEPTH_BIT:0]   rfr_count,
    input  logic                            rfr_abort,
    output logic                            rfr_busy,
    output logic                            rfr_done,
    output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_rd_addr,
    input  logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_rd_data,
    output logic                            rfr_out_valid,
    output logic [PAR_MEMORY_WIDTH_BIT-1:0] rfr_out_data,
    output logic                            rfr_out_last,
    input  logic                            rfr_out_ready
);

    localparam int unsigned AW = PAR_MEMORY_DEPTH_BIT;
    localparam int unsigned CW = PAR_MEMORY_DEPTH_BIT + 1;
    localparam int unsigned DW = PAR_MEMORY_WIDTH_BIT;

    rfr_state_e      state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_c;
    logic            start_ok_c;
    logic            last_word_c;

    // Output register may take a new word when empty or being consumed this cycle.
    assign load_c      = !out_valid_q || rfr_out_ready;
    assign start_ok_c  = rfr_start && !rfr_abort;
    assign last_word_c = (remain_q == CW'(1));

    always_ff @(posedge rfr_clk or posedge rfr_rst) begin
        if (rfr_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok_c && (rfr_count != '0)) state_d = ST_READ;
            end
            ST_READ: begin
                if (rfr_abort)                  state_d = ST_IDLE;
                else if (load_c && last_word_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (rfr_abort || rfr_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remain_d    = remain_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    if (rfr_count != '0) begin
                        addr_d   = rfr_start_addr;
                        remain_d = rfr_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rfr_abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    remain_d    = '0;
                end else if (load_c) begin
                    out_data_d  = rfm_rd_data;
                    out_valid_d = 1'b1;
                    out_last_d  = last_word_c;
                    addr_d      = addr_q + AW'(1);
                    remain_d    = remain_q - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (rfr_abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    remain_d    = '0;
                end else if (rfr_out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                remain_d    = '0;
            end
        endcase
    end

    always_ff @(posedge rfr_clk or posedge rfr_rst) begin
        if (rfr_rst) begin
            addr_q      <= '0;
            remain_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rfr_busy      = busy_q;
    assign rfr_done      = done_q;
    assign rfm_rd_addr   = addr_q;
    assign rfr_out_valid = out_valid_q;
    assign rfr_out_data  = out_data_q;
    assign rfr_out_last  = out_last_q;

endmodule

// File: tb/tb_qf_rfm_rdr.sv
// Directed bench for qf_rfm_rdr with a behavioural register file on the same clock.
module tb_qf_rfm_rdr;

    localparam int unsigned W = 64;
    localparam int unsigned D = 4;
    localparam int unsigned N = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [D-1:0]   start_addr;
    logic [D:0]     count;
    logic           abort;
    logic           busy;
    logic           done;
    logic [D-1:0]   rd_addr;
    logic [W-1:0]   rd_data;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;

    logic [W-1:0]   mem [N];
    logic           wr_en;
    logic [D-1:0]   wr_addr;
    logic [W-1:0]   wr_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];

    qf_rfm_rdr #(.PAR_MEMORY_WIDTH_BIT(W), .PAR_MEMORY_DEPTH_BIT(D)) dut (
        .rfr_clk(clk), .rfr_rst(rst), .rfr_start(start), .rfr_start_addr(start_addr),
        .rfr_count(count), .rfr_abort(abort), .rfr_busy(busy), .rfr_done(done),
        .rfm_rd_addr(rd_addr), .rfm_rd_data(rd_data), .rfr_out_valid(out_valid),
        .rfr_out_data(out_data), .rfr_out_last(out_last), .rfr_out_ready(out_ready)
    );

    function automatic logic [W-1:0] word(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_total++; if (busy !== 1'b0) $display("FAIL %s_busy: got %b want 0", tag, busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL %s_done: got %b want 0", tag, done); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL %s_valid: got %b want 0", tag, out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL %s_data: got %h want 0", tag, out_data); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL %s_last: got %b want 0", tag, out_last); else n_pass++;
        n_total++; if (rd_addr !== '0) $display("FAIL %s_rd_addr: got %0d want 0", tag, rd_addr); else n_pass++;
    endtask

    task automatic test_reset();
        check_reset_values("reset");
    endtask

    task automatic preload();
        for (int i = 0; i < int'(N); i++) begin
            wr_en = 1'b1; wr_addr = D'(i); wr_data = word(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_basic(input string tag);
        start = 1'b1; start_addr = 4'd3; count = 5'd4; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL %s_busy_start: got %b want 1", tag, busy); else n_pass++;
        n_total++; if (rd_addr !== 4'd3) $display("FAIL %s_rd_addr_start: got %0d want 3", tag, rd_addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL %s_valid_e0: got %b want 0", tag, out_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++; if (out_valid !== 1'b1) $display("FAIL %s_valid_%0d: got %b want 1", tag, i, out_valid); else n_pass++;
            n_total++; if (out_data !== word(3 + i)) $display("FAIL %s_data_%0d: got %h want %h", tag, i, out_data, word(3 + i)); else n_pass++;
            n_total++; if (out_last !== (i == 3)) $display("FAIL %s_last_%0d: got %b want %b", tag, i, out_last, (i == 3)); else n_pass++;
        end
        tick();
        n_total++; if (done !== 1'b1) $display("FAIL %s_done: got %b want 1", tag, done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", tag, busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL %s_valid_end: got %b want 0", tag, out_valid); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, done); else n_pass++;
    endtask

    task automatic test_wrap();
        int sa, cnt, k, cyc;
        for (int s = 0; s < 2; s++) begin
            sa  = (s == 0) ? 14 : 0;
            cnt = (s == 0) ? 3 : 16;
            start = 1'b1; start_addr = D'(sa); count = 5'(cnt); out_ready = 1'b1;
            tick();
            start = 1'b0;
            k = 0; cyc = 0;
            while (k < cnt && cyc < 40) begin
                if (out_valid) begin
                    n_total++; if (out_data !== word(sa + k)) $display("FAIL wrap%0d_data_%0d: got %h want %h", s, k, out_data, word(sa + k)); else n_pass++;
                    n_total++; if (out_last !== (k == cnt - 1)) $display("FAIL wrap%0d_last_%0d: got %b want %b", s, k, out_last, (k == cnt - 1)); else n_pass++;
                    k++;
                end
                tick(); cyc++;
            end
            n_total++; if (cyc !== cnt + 1) $display("FAIL wrap%0d_cycles: got %0d want %0d", s, cyc, cnt + 1); else n_pass++;
            n_total++; if (done !== 1'b1) $display("FAIL wrap%0d_done: got %b want 1", s, done); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL wrap%0d_busy: got %b want 0", s, busy); else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_pressure();
        logic [5:0]   pat = 6'b101001;
        logic         have_hold = 1'b0;
        logic [W-1:0] hold_data = '0;
        logic         hold_last = 1'b0;
        int k = 0, cyc = 0;
        start = 1'b1; start_addr = 4'd2; count = 5'd5; out_ready = 1'b0;
        tick();
        start = 1'b0;
        while (k < 5 && cyc < 60) begin
            out_ready = pat[cyc % 6];
            if (out_valid) begin
                if (have_hold) begin
                    n_total++; if (out_data !== hold_data || out_last !== hold_last) $display("FAIL bp_stable_%0d: got %h/%b want %h/%b", cyc, out_data, out_last, hold_data, hold_last); else n_pass++;
                end
                n_total++; if (out_data !== word(2 + k)) $display("FAIL bp_data_%0d: got %h want %h", k, out_data, word(2 + k)); else n_pass++;
                n_total++; if (out_last !== (k == 4)) $display("FAIL bp_last_%0d: got %b want %b", k, out_last, (k == 4)); else n_pass++;
                have_hold = !out_ready; hold_data = out_data; hold_last = out_last;
                if (out_ready) k++;
            end
            tick(); cyc++;
        end
        out_ready = 1'b1;
        n_total++; if (k !== 5) $display("FAIL bp_count: got %0d want 5", k); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_zero_count();
        start = 1'b1; start_addr = 4'd7; count = 5'd0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL zero_valid: got %b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL zero_idle: got valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int k = 0, cyc = 0;
        start = 1'b1; start_addr = 4'd5; count = 5'd4; out_ready = 1'b1;
        tick();
        while (k < 4 && cyc < 30) begin
            start = (cyc == 2); start_addr = 4'd0; count = 5'd2;
            if (out_valid) begin
                n_total++; if (out_data !== word(5 + k)) $display("FAIL ign_data_%0d: got %h want %h", k, out_data, word(5 + k)); else n_pass++;
                k++;
            end
            tick(); cyc++;
        end
        start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL ign_no_queue: got valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
    endtask

    task automatic test_abort();
        int k = 0, cyc = 0;
        start = 1'b1; start_addr = 4'd0; count = 5'd8; out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (k < 2 && cyc < 20) begin
            if (out_valid) k++;
            tick(); cyc++;
        end
        n_total++; if (out_data !== word(2) || out_valid !== 1'b1) $display("FAIL abort_pre: got %h/%b want %h/1", out_data, out_valid, word(2)); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0 || out_last !== 1'b0) $display("FAIL abort_done_last: got %b/%b want 0/0", done, out_last); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0 || out_valid !== 1'b0) $display("FAIL abort_after: got done %b valid %b want 0 0", done, out_valid); else n_pass++;
        start = 1'b1; abort = 1'b1; start_addr = 4'd1; count = 5'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_start_idle: got busy %b done %b want 0 0", busy, done); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL abort_start_valid: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; start_addr = 4'd9; count = 5'd6; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        #1 rst = 1'b0;
        test_basic("after_rst");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; abort = 1'b0;
        out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        test_reset();
        preload();
        rst = 1'b0;
        tick();
        test_basic("basic");
        test_wrap();
        test_back_pressure();
        test_zero_count();
        test_ignored_start();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
